if_id_pipe: RTL and testbench
=============================

// Module: if_id_pipe
// PURPOSE
//  Parametrised IF->ID pipeline stage with valid/ready handshake on both sides,
//  a 2-entry skid buffer, flush and bubble insertion. Sits between the fetch and
//  decode stages. Full throughput without a combinational ready path from ID to IF.
// PARAMETERS
//  ADDR_W    32            width of instruction address (pc)
//  INST_W    32            width of instruction word
//  NOP_INST  {INST_W{1'b0}} word driven on id_inst whenever id_valid=0
//  CNT_W     16            width of perf counters (used only with IF_ID_PERF_EN)
// PORTS
//  clk         in   1       single clock, all state updates on posedge
//  rst         in   1       synchronous reset, active-low
//  flush       in   1       kill everything held and in flight this cycle
//  if_valid    in   1       fetch offers if_pc/if_inst
//  if_ready    out  1       stage can accept; depends only on registered state
//  if_pc       in   ADDR_W  fetched instruction address
//  if_inst     in   INST_W  fetched instruction word
//  id_valid    out  1       decode-side data valid
//  id_ready    in   1       decode accepts this cycle
//  id_pc       out  ADDR_W  address to decode
//  id_inst     out  INST_W  instruction to decode
//  stall_cnt   out  CNT_W   cycles with id_valid=1 and id_ready=0 (IF_ID_PERF_EN only)
//  flush_cnt   out  CNT_W   cycles with flush=1 (IF_ID_PERF_EN only)
// BEHAVIOUR
//  - in_xfer = if_valid & if_ready; out_xfer = id_valid & id_ready.
//  - State: main reg (valid, pc, inst) drives id_*; skid reg (valid, pc, inst).
//  - if_ready = ~skid_valid, a registered flop. While rst=0, if_ready=0.
//    It becomes 1 in the first cycle after rst is released.
//  - Latency: an accepted entry appears on id_* in the next cycle when main is empty or draining.
//  - Next-state on posedge, priority order:
//    1. rst=0: main/skid valid=0, id_pc=0, id_inst=NOP_INST, counters=0.
//    2. flush=1: main/skid valid=0, id_pc=0, id_inst=NOP_INST.
//       Any same-cycle in_xfer is accepted and dropped.
//    3. main empty or out_xfer:
//       - If skid valid, main<=skid and skid<=input when in_xfer, else skid cleared.
//       - Else if in_xfer, main<=input.
//       - Else main valid=0 (bubble).
//    4. main full and not out_xfer: in_xfer writes skid. Main holds unchanged.
//  - Stability: while id_valid=1 and id_ready=0, id_pc/id_inst do not change.
//  - Bubble: id_valid=0 implies id_pc=0 and id_inst=NOP_INST.
//  - Order preserved strictly FIFO. Never more than 2 entries held.
//    No entry is lost except by flush or rst.
//  - Full: skid valid, so if_ready=0 and if_valid is ignored.
//    Empty: id_valid=0 regardless of id_ready.
//  - Reset mid-operation: both entries discarded, no output for the held data.
// CONFIGURATION
//  IF_ID_PERF_EN defined:
//   - stall_cnt and flush_cnt ports exist.
//   - Each counter increments by 1 per qualifying cycle and saturates at all-ones.
//   - Both counters clear on rst only, not on flush.
//  IF_ID_PERF_EN undefined:
//   - Counter ports and logic are absent. All other behaviour is identical.
// TESTING
//  1. rst=0 for 3 cycles -> id_valid=0, id_pc=0, id_inst=0, if_ready=0.
//     Cycle after release -> if_ready=1.
//  2. Stream pc 0x00,0x04,0x08 with if_valid=1 and id_ready=1 ->
//     id_pc 0x00,0x04,0x08 on consecutive cycles, each 1 cycle after acceptance.
//  3. Load 0x10, id_ready=0, offer 0x14 then 0x18:
//     - 0x14 goes to skid, if_ready=0, 0x18 stalls at fetch.
//     - id_pc holds 0x10.
//     - id_ready=1 -> 0x10, 0x14, 0x18 in order, none lost.
//  4. Main=0x20, skid=0x24, assert flush with if_valid=1 pc=0x28 ->
//     next cycle id_valid=0, id_inst=NOP_INST, if_ready=1, 0x28 never appears.
//  5. flush and rst=0 together -> reset values.
//     Flush in the cycle right after rst release -> id_valid stays 0.
//  6. With IF_ID_PERF_EN: 5 stall cycles then 2 flush cycles ->
//     stall_cnt=5, flush_cnt=2. With CNT_W=2 and 6 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/if_id_pipe.sv
// IF->ID pipeline register with a two-entry skid buffer, flush and bubbles.
// Optional perf counters (stall_cnt, flush_cnt) are built when IF_ID_PERF_EN is defined.
module if_id_pipe #(
  parameter int          ADDR_W   = 32,
  parameter int          INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}},
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
`ifdef IF_ID_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  localparam ent_t EMPTY = '{v: 1'b0, pc: '0, inst: NOP_INST};

  ent_t main_q, main_d;
  ent_t skid_q, skid_d;
  ent_t in_ent;
  logic rdy_q;
  logic in_xfer;
  logic out_xfer;
  logic drain;
  logic do_flush;
  logic do_move;
  logic do_hold;

  assign in_xfer  = if_valid & rdy_q;
  assign out_xfer = main_q.v & id_ready;
  assign drain    = ~main_q.v | out_xfer;

  assign do_flush = flush;
  assign do_move  = ~flush & drain;
  assign do_hold  = ~flush & ~drain;

  assign in_ent = '{v: 1'b1, pc: if_pc, inst: if_inst};

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    unique case (1'b1)
      do_flush: begin
        main_d = EMPTY;
        skid_d = EMPTY;
      end
      do_move: begin
        if (skid_q.v) begin
          main_d = skid_q;
          skid_d = in_xfer ? in_ent : EMPTY;
        end else if (in_xfer) begin
          main_d = in_ent;
        end else begin
          main_d = EMPTY;
        end
      end
      do_hold: begin
        if (in_xfer)
          skid_d = in_ent;
      end
      default: begin
        main_d = main_q;
        skid_d = skid_q;
      end
    endcase
  end

  // ready is registered from the next skid state, so no ID->IF comb path
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q <= EMPTY;
      skid_q <= EMPTY;
      rdy_q  <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      rdy_q  <= ~skid_d.v;
    end
  end

  assign if_ready = rdy_q;
  assign id_valid = main_q.v;
  assign id_pc    = main_q.pc;
  assign id_inst  = main_q.inst;

`ifdef IF_ID_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             stall_hit;

  assign stall_hit = main_q.v & ~id_ready;

  // saturating counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_hit && !(&stall_q))
        stall_q <= stall_q + 1'b1;
      if (flush && !(&flush_q))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Self-checking bench for if_id_pipe against a queue-based reference model.
// Define IF_ID_PERF_EN to also exercise the perf counters.
module tb_if_id_pipe;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int CW = 16;
  localparam logic [IW-1:0] NOP = '0;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          if_valid;
  logic          if_ready;
  logic [AW-1:0] if_pc;
  logic [IW-1:0] if_inst;
  logic          id_valid;
  logic          id_ready;
  logic [AW-1:0] id_pc;
  logic [IW-1:0] id_inst;
`ifdef IF_ID_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic          r2, iv2;
  logic [AW-1:0] ip2;
  logic [IW-1:0] ii2;
  logic [1:0]    st2, fl2;
`endif

  int nchk = 0;
  int nfail = 0;

  if_id_pipe #(.ADDR_W(AW), .INST_W(IW), .NOP_INST(NOP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst)
`ifdef IF_ID_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

`ifdef IF_ID_PERF_EN
  if_id_pipe #(.ADDR_W(AW), .INST_W(IW), .NOP_INST(NOP), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(r2),
    .if_pc(if_pc), .if_inst(if_inst),
    .id_valid(iv2), .id_ready(id_ready),
    .id_pc(ip2), .id_inst(ii2),
    .stall_cnt(st2), .flush_cnt(fl2)
  );
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } ment_t;

  ment_t mq[$];
  bit    mrdy = 1'b0;
  longint mstall = 0;
  longint mflush = 0;
  localparam longint CMAX = (64'd1 << CW) - 1;

  function automatic logic e_valid();
    return mq.size() > 0;
  endfunction

  function automatic logic [AW-1:0] e_pc();
    return (mq.size() > 0) ? mq[0].pc : '0;
  endfunction

  function automatic logic [IW-1:0] e_inst();
    return (mq.size() > 0) ? mq[0].inst : NOP;
  endfunction

  // advance one clock and the model: a FIFO of at most two held entries
  task automatic tick();
    bit acc;
    ment_t e;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      mrdy = 1'b0;
      mstall = 0;
      mflush = 0;
    end else begin
      if (mq.size() > 0 && !id_ready && mstall < CMAX) mstall++;
      if (flush && mflush < CMAX) mflush++;
      if (flush) begin
        mq.delete();
        mrdy = 1'b1;
      end else begin
        acc = if_valid && mrdy;
        if (mq.size() > 0 && id_ready) void'(mq.pop_front());
        if (acc) begin
          e.pc = if_pc;
          e.inst = if_inst;
          mq.push_back(e);
        end
        mrdy = (mq.size() < 2);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b0;
    if_pc = '0;
    if_inst = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      nchk++;
      if (id_valid !== 1'b0 || id_pc !== '0 || id_inst !== NOP || if_ready !== 1'b0) begin
        nfail++;
        $display("FAIL reset: v=%b pc=%h inst=%h rdy=%b required 0/0/0/0",
                 id_valid, id_pc, id_inst, if_ready);
      end
    end
    rst = 1'b1;
    tick();
    nchk++;
    if (if_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_release_ready: got %b required 1", if_ready);
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] pcs [3];
    logic [IW-1:0] ins [3];
    pcs[0] = 32'h00; pcs[1] = 32'h04; pcs[2] = 32'h08;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) ins[i] = $urandom;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1'b1;
      if_pc = pcs[i];
      if_inst = ins[i];
      tick();
      nchk++;
      if (id_valid !== 1'b1 || id_pc !== pcs[i] || id_inst !== ins[i]) begin
        nfail++;
        $display("FAIL stream[%0d]: v=%b pc=%h inst=%h required 1 %h %h",
                 i, id_valid, id_pc, id_inst, pcs[i], ins[i]);
      end
    end
    if_valid = 1'b0;
    tick();
    nchk++;
    if (id_valid !== 1'b0 || id_inst !== NOP || id_pc !== '0) begin
      nfail++;
      $display("FAIL stream_bubble: v=%b pc=%h inst=%h required 0 0 NOP",
               id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_skid();
    logic [AW-1:0] want [3];
    want[0] = 32'h10; want[1] = 32'h14; want[2] = 32'h18;
    id_ready = 1'b0;
    if_valid = 1'b1;
    if_pc = 32'h10; if_inst = 32'hA10;
    tick();
    if_pc = 32'h14; if_inst = 32'hA14;
    tick();
    nchk++;
    if (if_ready !== 1'b0 || id_pc !== 32'h10) begin
      nfail++;
      $display("FAIL skid_full: rdy=%b pc=%h required 0 00000010", if_ready, id_pc);
    end
    if_pc = 32'h18; if_inst = 32'hA18;
    tick();
    nchk++;
    if (if_ready !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h10 || id_inst !== 32'hA10) begin
      nfail++;
      $display("FAIL skid_hold: rdy=%b v=%b pc=%h inst=%h required 0 1 10 a10",
               if_ready, id_valid, id_pc, id_inst);
    end
    id_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      nchk++;
      if (id_valid !== 1'b1 || id_pc !== want[i]) begin
        nfail++;
        $display("FAIL skid_order[%0d]: v=%b pc=%h required 1 %h", i, id_valid, id_pc, want[i]);
      end
    end
    if_valid = 1'b0;
    tick();
    nchk++;
    if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
      nfail++;
      $display("FAIL skid_drained: v=%b rdy=%b required 0 1", id_valid, if_ready);
    end
  endtask

  task automatic test_flush();
    id_ready = 1'b0;
    if_valid = 1'b1;
    if_pc = 32'h20; if_inst = 32'hB20;
    tick();
    if_pc = 32'h24; if_inst = 32'hB24;
    tick();
    flush = 1'b1;
    if_pc = 32'h28; if_inst = 32'hB28;
    tick();
    nchk++;
    if (id_valid !== 1'b0 || id_inst !== NOP || id_pc !== '0 || if_ready !== 1'b1) begin
      nfail++;
      $display("FAIL flush_full: v=%b pc=%h inst=%h rdy=%b required 0 0 NOP 1",
               id_valid, id_pc, id_inst, if_ready);
    end
    // a transfer accepted in the flush cycle is dropped
    flush = 1'b1;
    if_pc = 32'h2C; if_inst = 32'hB2C;
    tick();
    flush = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nchk++;
      if (id_valid !== 1'b0 || id_pc !== '0) begin
        nfail++;
        $display("FAIL flush_dropped[%0d]: v=%b pc=%h required 0 0", i, id_valid, id_pc);
      end
    end
  endtask

  task automatic test_flush_reset();
    id_ready = 1'b0;
    if_valid = 1'b1;
    if_pc = 32'h30; if_inst = 32'hC30;
    tick();
    rst = 1'b0;
    flush = 1'b1;
    tick();
    nchk++;
    if (id_valid !== 1'b0 || id_pc !== '0 || id_inst !== NOP || if_ready !== 1'b0) begin
      nfail++;
      $display("FAIL flush_with_reset: v=%b pc=%h inst=%h rdy=%b required 0 0 NOP 0",
               id_valid, id_pc, id_inst, if_ready);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      nchk++;
      if (id_valid !== 1'b0) begin
        nfail++;
        $display("FAIL flush_after_release[%0d]: v=%b required 0", i, id_valid);
      end
    end
    flush = 1'b0;
    if_valid = 1'b0;
  endtask

  task automatic test_random();
    logic          held;
    logic [AW-1:0] hpc;
    logic [IW-1:0] hinst;
    for (int c = 0; c < 800; c++) begin
      held = id_valid && !id_ready;
      hpc = id_pc;
      hinst = id_inst;
      rst = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 24) == 0);
      held = held && rst && !flush;
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc = $urandom;
      if_inst = $urandom;
      tick();
      nchk++;
      if (id_valid !== e_valid() || id_pc !== e_pc() || id_inst !== e_inst()
          || if_ready !== mrdy) begin
        nfail++;
        $display("FAIL random[%0d]: v=%b pc=%h inst=%h rdy=%b required %b %h %h %b",
                 c, id_valid, id_pc, id_inst, if_ready, e_valid(), e_pc(), e_inst(), mrdy);
      end
      if (held) begin
        nchk++;
        if (id_pc !== hpc || id_inst !== hinst) begin
          nfail++;
          $display("FAIL random_stable[%0d]: pc=%h inst=%h required %h %h",
                   c, id_pc, id_inst, hpc, hinst);
        end
      end
`ifdef IF_ID_PERF_EN
      nchk++;
      if (stall_cnt !== CW'(mstall) || flush_cnt !== CW'(mflush)) begin
        nfail++;
        $display("FAIL random_cnt[%0d]: stall=%0d flush=%0d required %0d %0d",
                 c, stall_cnt, flush_cnt, mstall, mflush);
      end
`endif
      id_ready = ($urandom_range(0, 2) != 0);
    end
    rst = 1'b1;
    flush = 1'b0;
  endtask

`ifdef IF_ID_PERF_EN
  task automatic test_perf();
    rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    if_valid = 1'b1;
    id_ready = 1'b1;
    if_pc = 32'h40;
    tick();
    if_valid = 1'b0;
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    flush = 1'b0;
    nchk++;
    if (stall_cnt !== 16'd5 || flush_cnt !== 16'd2) begin
      nfail++;
      $display("FAIL perf_counts: stall=%0d flush=%0d required 5 2", stall_cnt, flush_cnt);
    end
    nchk++;
    if (st2 !== 2'd3 || fl2 !== 2'd2) begin
      nfail++;
      $display("FAIL perf_saturate: stall=%0d flush=%0d required 3 2", st2, fl2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_flush_reset();
    test_random();
`ifdef IF_ID_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
